// File: rtl/gmii_chk_pkg.sv
// Shared types and constants for the GMII frame checker.
package gmii_chk_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } chk_state_e;

  // CRC-32 (IEEE 802.3), MSB-first register fed LSB-first data bits
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int unsigned PRE_COUNT = 7;

  // Byte offsets after the SFD
  localparam int unsigned OFS_DA      = 0;
  localparam int unsigned OFS_TYPE    = 12;
  localparam int unsigned OFS_PROTO   = 23;
  localparam int unsigned OFS_DPORT   = 36;
  localparam int unsigned OFS_PAYLOAD = 42;

  localparam int unsigned MIN_HDR_LEN   = 38;
  localparam int unsigned MIN_FRAME_LEN = 64;
  localparam int unsigned MAX_FRAME_LEN = 1518;

  localparam int unsigned LEN_W     = 11;
  localparam int unsigned DLY_DEPTH = 4;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } dly_ent_t;

  // Byte idx of a MAC address in wire order (idx 0 = most significant)
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    return 8'(mac >> (6'd40 - {idx, 3'b000}));
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 update for one byte, data bit 0 first.
module crc32_d8
  import gmii_chk_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_next_c
);

  // Eight serial shift steps unrolled
  always_comb begin
    crc_next_c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_next_c[31] ^ data[i]) crc_next_c = {crc_next_c[30:0], 1'b0} ^ CRC_POLY;
      else                          crc_next_c = {crc_next_c[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/gmii_frame_checker.sv
// Checks GMII TX frames (preamble, MAC/IPv4/UDP header, FCS, length) and
// forwards the UDP payload through a four-byte delay line so FCS bytes drop out.
module gmii_frame_checker
  import gmii_chk_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h000A3501FEC0,
  parameter logic [15:0] UDP_PORT  = 16'd8080
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             gmii_en,
  input  logic             gmii_er,
  input  logic [7:0]       gmii_d,
  output logic             payload_valid,
  output logic [7:0]       payload_data,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic             hdr_err,
  output logic             phy_err,
  output logic [LEN_W-1:0] frame_len,
  output logic [15:0]      ok_cnt,
  output logic [15:0]      err_cnt
);

  chk_state_e state_q, state_d;
  logic [3:0]       pre_cnt_q, pre_cnt_d;
  logic [31:0]      crc_q, crc_d, crc_upd_c;
  logic [LEN_W-1:0] len_q, len_d, k;
  logic             mac_miss_q, mac_miss_d, bc_miss_q, bc_miss_d;
  logic             hdr_run_q, hdr_run_d, phy_run_q, phy_run_d;
  dly_ent_t [DLY_DEPTH-1:0] dly_q, dly_d;
  dly_ent_t         new_ent;

  logic             pv_d, fd_d, ok_d, crc_err_d, len_err_d, hdr_err_d, phy_err_d;
  logic [7:0]       pd_d;
  logic [LEN_W-1:0] frame_len_d;
  logic [15:0]      ok_cnt_d, err_cnt_d;

  crc32_d8 u_crc (
    .crc_in     (crc_q),
    .data       (gmii_d),
    .crc_next_c (crc_upd_c)
  );

  // Next-state, datapath and output logic
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    crc_d       = crc_q;
    len_d       = len_q;
    k           = len_q;
    mac_miss_d  = mac_miss_q;
    bc_miss_d   = bc_miss_q;
    hdr_run_d   = hdr_run_q;
    phy_run_d   = phy_run_q;
    dly_d       = dly_q;
    new_ent.vld = (len_q >= LEN_W'(OFS_PAYLOAD));
    new_ent.data = gmii_d;
    pv_d        = 1'b0;
    pd_d        = payload_data;
    fd_d        = 1'b0;
    ok_d        = frame_ok;
    crc_err_d   = crc_err;
    len_err_d   = len_err;
    hdr_err_d   = hdr_err;
    phy_err_d   = phy_err;
    frame_len_d = frame_len;
    ok_cnt_d    = ok_cnt;
    err_cnt_d   = err_cnt;

    case (state_q)
      WAIT_IDLE: if (!gmii_en) state_d = IDLE;

      // A non-preamble byte with en high is treated as a frame to skip
      IDLE: begin
        if (gmii_en) begin
          if (gmii_d == PRE_BYTE) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = DROP;
          end
        end
      end

      PREAMBLE: begin
        if (!gmii_en || gmii_er) begin
          state_d = DROP;
        end else if (gmii_d == PRE_BYTE) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (gmii_d == SFD_BYTE && pre_cnt_q == 4'(PRE_COUNT)) begin
          state_d    = DATA;
          crc_d      = CRC_INIT;
          len_d      = '0;
          mac_miss_d = 1'b0;
          bc_miss_d  = 1'b0;
          hdr_run_d  = 1'b0;
          phy_run_d  = 1'b0;
          dly_d      = '0;
        end else begin
          state_d = DROP;
        end
      end

      DATA: begin
        if (gmii_en) begin
          crc_d = crc_upd_c;
          if (len_q != '1) len_d = len_q + LEN_W'(1);
          if (gmii_er) phy_run_d = 1'b1;
          // Destination MAC: either our address or broadcast
          if ((k - LEN_W'(OFS_DA)) < LEN_W'(6)) begin
            if (gmii_d != mac_byte(LOCAL_MAC, 3'(k - LEN_W'(OFS_DA)))) mac_miss_d = 1'b1;
            if (gmii_d != 8'hFF) bc_miss_d = 1'b1;
          end
          if (k == LEN_W'(OFS_DA + 5) && mac_miss_d && bc_miss_d) hdr_run_d = 1'b1;
          if (k == LEN_W'(OFS_TYPE)      && gmii_d != 8'h08)          hdr_run_d = 1'b1;
          if (k == LEN_W'(OFS_TYPE + 1)  && gmii_d != 8'h00)          hdr_run_d = 1'b1;
          if (k == LEN_W'(OFS_PROTO)     && gmii_d != 8'h11)          hdr_run_d = 1'b1;
          if (k == LEN_W'(OFS_DPORT)     && gmii_d != UDP_PORT[15:8]) hdr_run_d = 1'b1;
          if (k == LEN_W'(OFS_DPORT + 1) && gmii_d != UDP_PORT[7:0])  hdr_run_d = 1'b1;
          // Oldest entry leaves the delay line; suppression takes effect on the faulting byte
          dly_d = {dly_q[DLY_DEPTH-2:0], new_ent};
          if (dly_q[DLY_DEPTH-1].vld && !hdr_run_d && !phy_run_d) begin
            pv_d = 1'b1;
            pd_d = dly_q[DLY_DEPTH-1].data;
          end
        end else begin
          fd_d        = 1'b1;
          crc_err_d   = (crc_q != CRC_RESIDUE);
          len_err_d   = (len_q < LEN_W'(MIN_FRAME_LEN)) || (len_q > LEN_W'(MAX_FRAME_LEN));
          hdr_err_d   = hdr_run_q || (len_q < LEN_W'(MIN_HDR_LEN));
          phy_err_d   = phy_run_q;
          ok_d        = !(crc_err_d || len_err_d || hdr_err_d || phy_err_d);
          frame_len_d = len_q;
          if (ok_d) ok_cnt_d  = ok_cnt + 16'd1;
          else      err_cnt_d = err_cnt + 16'd1;
          state_d     = IDLE;
        end
      end

      DROP: if (!gmii_en) state_d = IDLE;

      default: state_d = WAIT_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_IDLE;
      pre_cnt_q     <= '0;
      crc_q         <= '0;
      len_q         <= '0;
      mac_miss_q    <= 1'b0;
      bc_miss_q     <= 1'b0;
      hdr_run_q     <= 1'b0;
      phy_run_q     <= 1'b0;
      dly_q         <= '0;
      payload_valid <= 1'b0;
      payload_data  <= '0;
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      crc_err       <= 1'b0;
      len_err       <= 1'b0;
      hdr_err       <= 1'b0;
      phy_err       <= 1'b0;
      frame_len     <= '0;
      ok_cnt        <= '0;
      err_cnt       <= '0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      crc_q         <= crc_d;
      len_q         <= len_d;
      mac_miss_q    <= mac_miss_d;
      bc_miss_q     <= bc_miss_d;
      hdr_run_q     <= hdr_run_d;
      phy_run_q     <= phy_run_d;
      dly_q         <= dly_d;
      payload_valid <= pv_d;
      payload_data  <= pd_d;
      frame_done    <= fd_d;
      frame_ok      <= ok_d;
      crc_err       <= crc_err_d;
      len_err       <= len_err_d;
      hdr_err       <= hdr_err_d;
      phy_err       <= phy_err_d;
      frame_len     <= frame_len_d;
      ok_cnt        <= ok_cnt_d;
      err_cnt       <= err_cnt_d;
    end
  end

endmodule

// File: doc/gmii_frame_checker.md
GMII_FRAME_CHECKER -- requirements
Module: gmii_frame_checker

Interface
REQ-001 Parameter LOCAL_MAC, 48'h000A3501FEC0, accepted destination MAC; broadcast FF:FF:FF:FF:FF:FF is also accepted.
REQ-002 Parameter UDP_PORT, 16'd8080, accepted UDP destination port.
REQ-003 sys_clk  in  1  single clock (GMII TX clock domain, 125 MHz); all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 gmii_en  in  1  GMII TXEN from upstream UDP/GMII transmitter.
REQ-006 gmii_er  in  1  GMII TXER.
REQ-007 gmii_d  in  8  GMII TXD.
REQ-008 payload_valid  out  1  UDP payload byte strobe.
REQ-009 payload_data  out  8  UDP payload byte.
REQ-010 frame_done  out  1  one-cycle pulse at frame end; status outputs valid in the same cycle.
REQ-011 frame_ok  out  1  no error flags set.
REQ-012 crc_err, len_err, hdr_err, phy_err  out  1 each  frame error flags.
REQ-013 frame_len  out  11  bytes after SFD including FCS, saturating at 2047.
REQ-014 ok_cnt, err_cnt  out  16 each  good and bad frame counters; wrap 0xFFFF->0.

Function
REQ-015 FSM states: WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP.
REQ-016 WAIT_IDLE -> IDLE on the first cycle with gmii_en=0.
REQ-017 IDLE -> PREAMBLE when gmii_en=1 and gmii_d=0x55; the preamble count is 1.
REQ-018 PREAMBLE: each 0x55 increments the count; 0xD5 with count==7 -> DATA; any other byte, 0xD5 with count!=7, gmii_er=1 or gmii_en=0 -> DROP.
REQ-019 DROP -> IDLE when gmii_en=0; preamble faults never pulse frame_done or change counters.
REQ-020 DATA: each byte updates CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) and frame_len; byte index k counts from 0 after the SFD.
REQ-021 Header checks (hdr_err): bytes 0-5 equal LOCAL_MAC or broadcast; bytes 12-13 equal 0x0800; byte 23 equals 0x11; bytes 36-37 equal UDP_PORT.
REQ-022 gmii_er=1 on any DATA cycle sets phy_err.
REQ-023 Four-byte delay line: payload byte k (k>=42) is driven on payload_data, with payload_valid=1, on the edge that samples byte k+4 with gmii_en=1 (4-cycle latency).
REQ-024 FCS bytes are therefore never emitted.
REQ-025 payload_valid is suppressed for the rest of the frame once hdr_err or phy_err is set.
REQ-026 DATA with gmii_en=0 ends the frame: frame_done=1 for one cycle, then -> IDLE.
REQ-027 At frame end, crc_err=1 if the un-inverted CRC register is not 0xC704DD7B.
REQ-028 At frame end, len_err=1 if frame_len<64 or frame_len>1518.
REQ-029 Frames shorter than 38 bytes also set hdr_err.
REQ-030 frame_ok is the NOR of the four flags; ok_cnt or err_cnt increments on the frame_done edge.
REQ-031 Status flags and frame_len hold until the next frame_done.
REQ-032 gmii_en dropping and rising again on consecutive cycles is legal: the frame ends normally and the new byte is evaluated in IDLE on the following cycle.

Reset
REQ-033 rst_n=0 immediately clears all outputs, counters, the CRC register and the delay line to 0, and forces WAIT_IDLE.
REQ-034 A frame in progress when reset asserts is discarded: no frame_done and no counter change.
REQ-035 If reset releases while gmii_en=1, the rest of that frame is ignored.

Structure
REQ-036 Shared package gmii_chk_pkg holds the state enum, the CRC polynomial and residue, header offsets (0, 12, 23, 36, 42) and the length limits 64/1518.
REQ-037 One sub-module, crc32_d8: combinational next-CRC for one byte, instantiated once.

Verification
REQ-038 Good frame: 7x0x55, 0xD5, valid header, payload 0x00..0x11, correct FCS -> 18 payload_valid pulses carrying 0x00..0x11, then frame_done, frame_ok=1, frame_len=64, ok_cnt=1.
REQ-039 Same frame with payload byte 5 XOR 0x01 -> payload still output, crc_err=1, frame_ok=0, err_cnt=1.
REQ-040 UDP dest port 8081 -> zero payload_valid pulses, hdr_err=1, err_cnt increments.
REQ-041 Six 0x55 then 0xD5 -> no frame_done, counters unchanged; the next good frame gives frame_ok=1.
REQ-042 rst_n pulsed low at byte 30 and released with gmii_en still high -> no frame_done and all outputs 0; the following good frame gives ok_cnt=1.
REQ-043 gmii_er high at byte 50 of a 64-byte frame -> payload stops, phy_err=1; a separate 1519-byte frame -> len_err=1.
